// File: rtl/i2c_master_slave_pkg.sv
// Shared types and defaults for the I2C master/slave pair.
package i2c_master_slave_pkg;

  localparam logic [6:0]  DEFAULT_ADDR    = 7'h50;
  localparam int unsigned DEFAULT_SCL_DIV = 4;

  typedef enum logic [2:0] {
    M_IDLE,
    M_START,
    M_ADDR,
    M_ADDR_ACK,
    M_DATA,
    M_DATA_ACK,
    M_STOP
  } master_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WR_ACK,
    S_READ,
    S_RD_ACK,
    S_IGNORE
  } slave_state_e;

endpackage

// File: rtl/i2c_master_slave_master.sv
// I2C master: generates SCL and runs one single-byte transaction per
// START/STOP pair while enabled.
module i2c_master
  import i2c_master_slave_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = DEFAULT_ADDR,
  parameter int unsigned SCL_DIV     = DEFAULT_SCL_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       read_write,
  input  logic [7:0] data_write,
  input  logic       sda,
  output logic       scl,
  output logic       sda_pull,
  output logic [7:0] data
);

  localparam int unsigned   CW        = $clog2(SCL_DIV);
  localparam logic [CW-1:0] HALF      = CW'(SCL_DIV / 2);
  localparam logic [CW-1:0] LAST      = CW'(SCL_DIV - 1);
  // SDA is registered, so it is loaded one cycle before the point it must appear
  localparam logic [CW-1:0] LOAD_LOW  = CW'((SCL_DIV / 2) / 2 - 1);
  localparam logic [CW-1:0] LOAD_HIGH = CW'(SCL_DIV / 2 + (SCL_DIV / 2) / 2 - 1);

  master_state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    addr_byte, wdata_lat, rx;
  logic          rw_lat, ack_ok, pull_nxt, period_end;

  assign period_end = (cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= M_IDLE;
    else     state <= state_nxt;
  end

  // Next state: advance only at the end of an SCL period
  always_comb begin
    state_nxt = state;
    if (period_end) begin
      case (state)
        M_IDLE:     if (enable) state_nxt = M_START;
        M_START:    state_nxt = M_ADDR;
        M_ADDR:     if (bit_cnt == 3'd0) state_nxt = M_ADDR_ACK;
        M_ADDR_ACK: state_nxt = ack_ok ? M_DATA : M_STOP;
        M_DATA:     if (bit_cnt == 3'd0) state_nxt = M_DATA_ACK;
        M_DATA_ACK: state_nxt = M_STOP;
        M_STOP:     state_nxt = M_IDLE;
        default:    state_nxt = M_IDLE;
      endcase
    end
  end

  // Outputs: SCL shape per state and the SDA pull level for the next load point
  always_comb begin
    scl      = (cnt >= HALF);
    pull_nxt = 1'b0;
    case (state)
      M_IDLE:  scl = 1'b1;
      M_START: begin
        scl      = (cnt < HALF);
        pull_nxt = 1'b1;
      end
      M_ADDR:  pull_nxt = ~addr_byte[bit_cnt];
      M_DATA:  pull_nxt = rw_lat & ~wdata_lat[bit_cnt];
      M_STOP:  pull_nxt = (cnt == LOAD_LOW);
      default: pull_nxt = 1'b0;
    endcase
  end

  // Datapath: period counter, bit counter, latches, SDA drive and read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bit_cnt   <= 3'd7;
      addr_byte <= '0;
      wdata_lat <= '0;
      rw_lat    <= 1'b0;
      ack_ok    <= 1'b0;
      rx        <= '0;
      data      <= '0;
      sda_pull  <= 1'b0;
    end else begin
      cnt <= period_end ? '0 : cnt + CW'(1);
      if (cnt == LOAD_LOW || (state == M_STOP && cnt == LOAD_HIGH))
        sda_pull <= pull_nxt;
      if (period_end) begin
        if (state_nxt != state)                     bit_cnt <= 3'd7;
        else if (state == M_ADDR || state == M_DATA) bit_cnt <= bit_cnt - 3'd1;
        if (state == M_IDLE && state_nxt == M_START) begin
          addr_byte <= {TARGET_ADDR, ~read_write};
          wdata_lat <= data_write;
          rw_lat    <= read_write;
        end
      end
      if (cnt == HALF) begin
        if (state == M_ADDR_ACK)             ack_ok <= ~sda;
        if (state == M_DATA && !rw_lat)      rx     <= {rx[6:0], sda};
        if (state == M_DATA_ACK && !rw_lat)  data   <= rx;
      end
    end
  end

endmodule

// File: rtl/i2c_master_slave_slave.sv
// I2C slave: oversamples SCL/SDA in the clk domain, answers one address,
// stores written bytes and returns the stored byte on reads.
module i2c_slave
  import i2c_master_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_pull,
  output logic [7:0] data_received
);

  slave_state_e state, state_nxt;
  logic       scl_q, sda_q, scl_rise, scl_fall, start_cond, stop_cond;
  logic [3:0] bit_cnt;
  logic [7:0] sr, sr_in;

  // Bus events from comparison with the previous-cycle sample
  always_comb begin
    scl_rise   = scl & ~scl_q;
    scl_fall   = ~scl & scl_q;
    start_cond = scl & scl_q & sda_q & ~sda;
    stop_cond  = scl & scl_q & ~sda_q & sda;
    sr_in      = {sr[6:0], sda};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: STOP/START win, otherwise progress on SCL falling edges
  always_comb begin
    state_nxt = state;
    if (stop_cond)
      state_nxt = S_IDLE;
    else if (start_cond && (enable || state != S_IDLE))
      state_nxt = S_ADDR;
    else if (scl_fall) begin
      case (state)
        S_ADDR:     if (bit_cnt == 4'd8)
                      state_nxt = (sr[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: state_nxt = sr[0] ? S_READ : S_WRITE;
        S_WRITE:    if (bit_cnt == 4'd8) state_nxt = S_WR_ACK;
        S_WR_ACK:   state_nxt = S_IDLE;
        S_READ:     if (bit_cnt == 4'd8) state_nxt = S_RD_ACK;
        S_RD_ACK:   state_nxt = S_IDLE;
        default:    state_nxt = state;
      endcase
    end
  end

  // Output: pull SDA for ACKs and for zero bits while transmitting
  always_comb begin
    sda_pull = 1'b0;
    case (state)
      S_ADDR_ACK, S_WR_ACK: sda_pull = 1'b1;
      S_READ:               sda_pull = ~sr[7];
      default:              sda_pull = 1'b0;
    endcase
  end

  // Datapath: edge history, bit counting, shift register, received byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q         <= 1'b1;
      sda_q         <= 1'b1;
      bit_cnt       <= '0;
      sr            <= '0;
      data_received <= '0;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
      if (stop_cond || start_cond || state_nxt != state)
        bit_cnt <= '0;
      else if (scl_rise && bit_cnt != 4'd8 &&
               (state == S_ADDR || state == S_WRITE || state == S_READ))
        bit_cnt <= bit_cnt + 4'd1;
      if (state == S_ADDR_ACK && state_nxt == S_READ)
        sr <= data_received;
      else if (state == S_READ && scl_fall && bit_cnt != 4'd8)
        sr <= {sr[6:0], 1'b0};
      else if (scl_rise && bit_cnt != 4'd8 && (state == S_ADDR || state == S_WRITE))
        sr <= sr_in;
      if (state == S_WRITE && scl_rise && bit_cnt == 4'd7 && !stop_cond && !start_cond)
        data_received <= sr_in;
    end
  end

endmodule

// File: rtl/i2c_master_slave.sv
// Top: master and slave sharing an internal open-drain SDA line.
module i2c_master_slave
  import i2c_master_slave_pkg::*;
#(
  parameter logic [6:0]  MASTER_TARGET_ADDR = DEFAULT_ADDR,
  parameter logic [6:0]  SLAVE_ADDR         = DEFAULT_ADDR,
  parameter int unsigned SCL_DIV            = DEFAULT_SCL_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       read_write,
  input  logic [7:0] data_write,
  output logic       scl,
  output logic [7:0] data,
  output logic [7:0] data_received
);

  logic sda, master_pull, slave_pull;

  // Wired-AND: the line is high unless someone pulls it low
  assign sda = ~master_pull & ~slave_pull;

  i2c_master #(
    .TARGET_ADDR (MASTER_TARGET_ADDR),
    .SCL_DIV     (SCL_DIV)
  ) u_master (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .read_write (read_write),
    .data_write (data_write),
    .sda        (sda),
    .scl        (scl),
    .sda_pull   (master_pull),
    .data       (data)
  );

  i2c_slave #(
    .SLAVE_ADDR (SLAVE_ADDR)
  ) u_slave (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .scl           (scl),
    .sda           (sda),
    .sda_pull      (slave_pull),
    .data_received (data_received)
  );

endmodule

// File: tb/tb_i2c_master_slave.sv
// Directed bench for i2c_master_slave: decodes the bus from scl/SDA and
// checks bytes, ACK bits and output registers against hand-derived values.
module tb_i2c_master_slave;

  logic       clk = 1'b0;
  logic       rst, enable, en_mm, read_write;
  logic [7:0] data_write;
  logic       scl, scl_mm;
  logic [7:0] data, data_mm, dr, dr_mm;

  int         n_asserts = 0;
  int         n_fail    = 0;

  logic [7:0] ab, db;
  logic       aa, da;
  int         nb, ns, got;

  always #5 clk = ~clk;

  i2c_master_slave dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .read_write    (read_write),
    .data_write    (data_write),
    .scl           (scl),
    .data          (data),
    .data_received (dr)
  );

  i2c_master_slave #(
    .MASTER_TARGET_ADDR (7'h51)
  ) dut_mm (
    .clk           (clk),
    .rst           (rst),
    .enable        (en_mm),
    .read_write    (read_write),
    .data_write    (data_write),
    .scl           (scl_mm),
    .data          (data_mm),
    .data_received (dr_mm)
  );

  function automatic logic [1:0] bus(input bit sel);
    if (sel) return {scl_mm, dut_mm.sda};
    return {scl, dut.sda};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Negedges until a START condition; -1 if none within budget
  task automatic wait_start(input bit sel, input int budget, output int ncyc);
    logic [1:0] prev, cur;
    prev = bus(sel);
    ncyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      cur = bus(sel);
      if (cur[1] && prev[1] && prev[0] && !cur[0]) begin
        ncyc = i;
        break;
      end
      prev = cur;
    end
  endtask

  task automatic wait_rises(input int n, output int cnt);
    logic [1:0] prev, cur;
    prev = bus(1'b0);
    cnt  = 0;
    for (int i = 0; i < 400 && cnt < n; i++) begin
      @(negedge clk);
      cur = bus(1'b0);
      if (cur[1] && !prev[1]) cnt++;
      prev = cur;
    end
  endtask

  // One transaction: bits sampled at scl rising edges until STOP
  task automatic capture(input bit sel, output logic [7:0] abyte, output logic aack,
                         output logic [7:0] dbyte, output logic dack, output int nbits);
    logic [1:0]  prev, cur;
    logic [18:0] bits;
    int          st;
    bit          done;
    bits  = '0;
    nbits = 0;
    done  = 1'b0;
    wait_start(sel, 200, st);
    if (st < 0) nbits = -1;
    else begin
      prev = bus(sel);
      for (int i = 0; i < 200 && !done; i++) begin
        @(negedge clk);
        cur = bus(sel);
        if (cur[1] && !prev[1]) begin
          bits = {bits[17:0], cur[0]};
          nbits++;
        end else if (cur[1] && prev[1] && !prev[0] && cur[0]) done = 1'b1;
        prev = cur;
      end
      if (!done) nbits = -1;
      else begin
        bits  = bits >> 1;   // drop the scl rise belonging to STOP
        nbits = nbits - 1;
      end
    end
    if (nbits == 9) bits = bits << 9;
    abyte = bits[17:10];
    aack  = bits[9];
    dbyte = bits[8:1];
    dack  = bits[0];
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    en_mm      = 1'b0;
    read_write = 1'b1;
    data_write = 8'hB3;

    // Reset state
    repeat (10) @(negedge clk);
    check("rst_scl", 32'(scl), 32'h1);
    check("rst_sda", 32'(dut.sda), 32'h1);
    check("rst_data", 32'(data), 32'h00);
    check("rst_data_received", 32'(dr), 32'h00);

    // First START after one full idle SCL period
    rst = 1'b0;
    wait_start(1'b0, 200, ns);
    check("start_latency", 32'(ns), 32'd5);

    // Abort during DATA bit 4 of the first write
    wait_rises(13, got);
    check("abort_reach_bit4", 32'(got), 32'd13);
    rst = 1'b1;
    @(negedge clk);
    check("abort_scl", 32'(scl), 32'h1);
    check("abort_sda", 32'(dut.sda), 32'h1);
    check("abort_data_received", 32'(dr), 32'h00);
    check("abort_data", 32'(data), 32'h00);
    @(negedge clk);
    rst = 1'b0;

    // Write 0xB3
    capture(1'b0, ab, aa, db, da, nb);
    check("wr_nbits", 32'(nb), 32'd18);
    check("wr_addr", 32'(ab), 32'hA0);
    check("wr_addr_ack", 32'(aa), 32'h0);
    check("wr_byte", 32'(db), 32'hB3);
    check("wr_data_ack", 32'(da), 32'h0);
    check("wr_data_received", 32'(dr), 32'hB3);
    check("wr_data_untouched", 32'(data), 32'h00);

    // Back-to-back: data_write changes mid-transaction
    fork
      capture(1'b0, ab, aa, db, da, nb);
      begin
        repeat (40) @(negedge clk);
        data_write = 8'hBC;
      end
    join
    check("b2b1_byte", 32'(db), 32'hB3);
    check("b2b1_data_received", 32'(dr), 32'hB3);
    capture(1'b0, ab, aa, db, da, nb);
    check("b2b2_nbits", 32'(nb), 32'd18);
    check("b2b2_byte", 32'(db), 32'hBC);
    check("b2b2_data_received", 32'(dr), 32'hBC);

    // Write 0xB3 again, then read it back
    data_write = 8'hB3;
    capture(1'b0, ab, aa, db, da, nb);
    check("wr2_byte", 32'(db), 32'hB3);
    check("wr2_data_received", 32'(dr), 32'hB3);
    read_write = 1'b0;
    capture(1'b0, ab, aa, db, da, nb);
    check("rd_nbits", 32'(nb), 32'd18);
    check("rd_addr", 32'(ab), 32'hA1);
    check("rd_addr_ack", 32'(aa), 32'h0);
    check("rd_byte", 32'(db), 32'hB3);
    check("rd_master_nack", 32'(da), 32'h1);
    check("rd_data", 32'(data), 32'hB3);

    // enable drops mid-read: transaction completes, then bus stays idle
    fork
      capture(1'b0, ab, aa, db, da, nb);
      begin
        repeat (40) @(negedge clk);
        enable = 1'b0;
      end
    join
    check("endrop_nbits", 32'(nb), 32'd18);
    check("endrop_byte", 32'(db), 32'hB3);
    check("endrop_nack", 32'(da), 32'h1);
    check("endrop_data", 32'(data), 32'hB3);
    wait_start(1'b0, 100, ns);
    check("endrop_no_restart", 32'(ns), 32'hFFFF_FFFF);
    check("endrop_scl_idle", 32'(scl), 32'h1);
    check("endrop_sda_idle", 32'(dut.sda), 32'h1);

    // Address mismatch: NACK, straight to STOP
    read_write = 1'b1;
    en_mm      = 1'b1;
    capture(1'b1, ab, aa, db, da, nb);
    en_mm = 1'b0;
    check("mm_nbits", 32'(nb), 32'd9);
    check("mm_addr", 32'(ab), 32'hA2);
    check("mm_addr_nack", 32'(aa), 32'h1);
    check("mm_data_received", 32'(dr_mm), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
